// File: rtl/led_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_pattern_gen: debounced-button mode select over COUNT/SCAN/BREATHE LEDs |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module led_pattern_gen #(
   parameter int LEDS_NR    = 6,
   parameter int PRESCALE_W = 20,
   parameter int DEBOUNCE_W = 16,
   parameter int PWM_W      = 8,
   parameter bit INV_BTN    = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_i,
   input  logic               en_i,
   output logic [LEDS_NR-1:0] led,
   output logic [1:0]         mode_o
);

   localparam int                 POS_W     = $clog2(LEDS_NR);
   localparam logic [POS_W-1:0]   c_POS_MAX = POS_W'(LEDS_NR - 1);
   localparam logic [PWM_W-1:0]   c_DUTY_MAX = '1;
   localparam logic [LEDS_NR-1:0] c_ONE     = LEDS_NR'(1);

   typedef enum logic [1:0] {
      MODE_COUNT   = 2'd0,
      MODE_SCAN    = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_RSVD    = 2'd3
   } mode_t;

   logic                  r_key_meta;
   logic                  r_key_sync;
   logic                  w_key_s;
   logic                  r_stable;
   logic                  r_stable_d;
   logic [DEBOUNCE_W-1:0] r_dcnt;
   logic                  w_press;

   logic [PRESCALE_W-1:0] r_pre;
   logic                  w_tick;
   logic                  w_step;

   mode_t                 r_mode;
   mode_t                 w_mode_nxt;

   logic [LEDS_NR-1:0]    r_cnt;
   logic [POS_W-1:0]      r_pos;
   logic                  r_scan_dn;
   logic [PWM_W-1:0]      r_pwm;
   logic [PWM_W-1:0]      r_duty;
   logic                  r_duty_dn;
   logic [LEDS_NR-1:0]    w_led_nxt;

   // Key synchronizer and debounce
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_meta <= 1'b0;
         r_key_sync <= 1'b0;
      end else begin
         r_key_meta <= key_i;
         r_key_sync <= r_key_meta;
      end
   end

   assign w_key_s = r_key_sync ^ INV_BTN;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
         r_dcnt     <= '0;
      end else begin
         r_stable_d <= r_stable;
         if (w_key_s == r_stable) begin
            r_dcnt <= '0;
         end else if (&r_dcnt) begin
            r_stable <= w_key_s;
            r_dcnt   <= '0;
         end else begin
            r_dcnt <= r_dcnt + DEBOUNCE_W'(1);
         end
      end
   end

   // Press fires only on the rising edge of the debounced level
   assign w_press = r_stable & ~r_stable_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
      end else if (en_i) begin
         r_pre <= r_pre + PRESCALE_W'(1);
      end
   end

   assign w_tick = en_i & (&r_pre);
   assign w_step = w_tick & ~w_press;

   // Mode state machine
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode <= MODE_COUNT;
      end else begin
         r_mode <= w_mode_nxt;
      end
   end

   always_comb begin
      w_mode_nxt = r_mode;
      if (w_press) begin
         case (r_mode)
            MODE_COUNT: w_mode_nxt = MODE_SCAN;
            MODE_SCAN:  w_mode_nxt = MODE_BREATHE;
            default:    w_mode_nxt = MODE_COUNT;
         endcase
      end
   end

   assign mode_o = r_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_press) begin
         r_cnt <= '0;
      end else if (w_step && (r_mode == MODE_COUNT)) begin
         r_cnt <= r_cnt + LEDS_NR'(1);
      end
   end

   // Bounce: each end position is visited once before reversing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pos     <= '0;
         r_scan_dn <= 1'b0;
      end else if (w_press) begin
         r_pos     <= '0;
         r_scan_dn <= 1'b0;
      end else if (w_step && (r_mode == MODE_SCAN)) begin
         if (!r_scan_dn) begin
            if (r_pos == c_POS_MAX) begin
               r_pos     <= r_pos - POS_W'(1);
               r_scan_dn <= 1'b1;
            end else begin
               r_pos <= r_pos + POS_W'(1);
            end
         end else begin
            if (r_pos == '0) begin
               r_pos     <= r_pos + POS_W'(1);
               r_scan_dn <= 1'b0;
            end else begin
               r_pos <= r_pos - POS_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm <= '0;
      end else begin
         r_pwm <= r_pwm + PWM_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_duty    <= '0;
         r_duty_dn <= 1'b0;
      end else if (w_press) begin
         r_duty    <= '0;
         r_duty_dn <= 1'b0;
      end else if (w_step && (r_mode == MODE_BREATHE)) begin
         if (!r_duty_dn) begin
            if (r_duty == c_DUTY_MAX) begin
               r_duty    <= r_duty - PWM_W'(1);
               r_duty_dn <= 1'b1;
            end else begin
               r_duty <= r_duty + PWM_W'(1);
            end
         end else begin
            if (r_duty == '0) begin
               r_duty    <= r_duty + PWM_W'(1);
               r_duty_dn <= 1'b0;
            end else begin
               r_duty <= r_duty - PWM_W'(1);
            end
         end
      end
   end

   always_comb begin
      w_led_nxt = '0;
      case (r_mode)
         MODE_COUNT:   w_led_nxt = r_cnt;
         MODE_SCAN:    w_led_nxt = c_ONE << r_pos;
         MODE_BREATHE: w_led_nxt = {LEDS_NR{(r_pwm < r_duty)}};
         default:      w_led_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led <= '0;
      end else begin
         led <= w_led_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_led_pattern_gen: directed bench for led_pattern_gen (4 LEDs, fast rates) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_led_pattern_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key_i;
   logic       en_i;
   logic [3:0] led;
   logic [1:0] mode_o;

   int checks   = 0;
   int failures = 0;
   int edge_cnt;
   int rel_edge = -1;

   logic [3:0] exp_scan [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0100, 4'b0010, 4'b0001, 4'b0010};
   int exp_duty [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

   led_pattern_gen #(
      .LEDS_NR   (4),
      .PRESCALE_W(3),
      .DEBOUNCE_W(2),
      .PWM_W     (3),
      .INV_BTN   (1'b0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .key_i (key_i),
      .en_i  (en_i),
      .led   (led),
      .mode_o(mode_o)
   );

   always #5 clk = ~clk;

   // Edges since reset release; the prescaler and PWM phase follow it while en_i=1
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_edge(input int target);
      while (edge_cnt < target) begin
         cyc(1);
         if (edge_cnt == rel_edge) key_i = 1'b0;
      end
   endtask

   function automatic int next_phase(input int p);
      int e;
      e = edge_cnt + 1;
      while ((e % 8) != p) e++;
      return e;
   endfunction

   initial begin
      int e_s, f_s, g_s, h_s;
      int lit, bad, holds;
      rst_n = 1'b0;
      key_i = 1'b0;
      en_i  = 1'b1;
      cyc(3);
      check("reset_led", led, 0);
      check("reset_mode", mode_o, 0);
      rst_n = 1'b1;

      // COUNT from reset: led n appears at edge 8n+1
      for (int n = 1; n <= 16; n++) begin
         wait_edge(8 * n);
         check("count_hold", led, (n - 1) % 16);
         wait_edge(8 * n + 1);
         check("count_step", led, n % 16);
      end
      check("count_mode", mode_o, 0);

      // Short glitch is filtered
      wait_edge(130);
      key_i = 1'b1;
      wait_edge(132);
      key_i = 1'b0;
      wait_edge(140);
      check("glitch_mode", mode_o, 0);

      // Long press: key_s at +2, stable at +6, mode at +7
      e_s = next_phase(2);
      wait_edge(e_s);
      key_i    = 1'b1;
      rel_edge = e_s + 20;
      wait_edge(e_s + 6);
      check("press_early", mode_o, 0);
      wait_edge(e_s + 7);
      check("press_mode1", mode_o, 1);
      wait_edge(e_s + 8);
      check("scan_start", led, exp_scan[0]);
      for (int k = 1; k < 8; k++) begin
         wait_edge(e_s + 6 + 8 * k);
         check("scan_hold", led, exp_scan[k-1]);
         wait_edge(e_s + 7 + 8 * k);
         check("scan_step", led, exp_scan[k]);
      end
      check("single_press", mode_o, 1);

      // BREATHE: each duty window of 8 cycles has exactly duty lit cycles
      f_s = next_phase(2);
      wait_edge(f_s);
      key_i    = 1'b1;
      rel_edge = f_s + 20;
      wait_edge(f_s + 6);
      check("press2_early", mode_o, 1);
      wait_edge(f_s + 7);
      check("press2_mode2", mode_o, 2);
      bad = 0;
      for (int j = 0; j < 16; j++) begin
         lit = 0;
         for (int s = (j == 0) ? 1 : 0; s < 8; s++) begin
            wait_edge(f_s + 7 + 8 * j + s);
            if (led == 4'hF) lit++;
            else if (led != 4'h0) bad++;
            if (j == 3) check("breathe_d3", led, (s < 3) ? 4'hF : 4'h0);
         end
         check("breathe_duty", lit, exp_duty[j]);
      end
      check("breathe_shape", bad, 0);
      check("breathe_mode", mode_o, 2);

      // Third press lands on the same cycle as a tick
      g_s = next_phase(1);
      wait_edge(g_s);
      key_i    = 1'b1;
      rel_edge = g_s + 20;
      wait_edge(g_s + 6);
      check("press3_early", mode_o, 2);
      wait_edge(g_s + 7);
      check("press3_mode0", mode_o, 0);
      wait_edge(g_s + 8);
      check("restart_led", led, 0);
      wait_edge(g_s + 15);
      check("coinc_no_step", led, 0);
      wait_edge(g_s + 16);
      check("restart_step", led, 1);
      wait_edge(g_s + 48);
      check("count_five", led, 5);

      // Freeze
      en_i  = 1'b0;
      holds = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         if (led == 4'd5) holds++;
      end
      check("freeze_hold", holds, 100);
      check("freeze_mode", mode_o, 0);
      h_s  = edge_cnt;
      en_i = 1'b1;
      wait_edge(h_s + 7);
      check("resume_hold", led, 5);
      wait_edge(h_s + 8);
      check("resume_step", led, 6);

      // Asynchronous reset between clock edges
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_led", led, 0);
      check("async_rst_mode", mode_o, 0);
      cyc(2);
      rst_n = 1'b1;
      wait_edge(8);
      check("rerun_hold", led, 0);
      wait_edge(9);
      check("rerun_step", led, 1);
      check("rerun_mode", mode_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
